key_debouncer: RTL and testbench
================================

# key_debouncer

Debounces and synchronises one raw active-low pushbutton and turns it into a clean level, single-cycle press/release strobes and an 8-bit press count. It sits directly upstream of the LED blink chain. `press_pulse` is the strobe the blink counter and LED toggler consume in place of a raw `KEY` level. It runs on the board's 50 MHz clock, so a bouncing mechanical contact can never produce a spurious toggle or counter clear.

## Interface
- `STABLE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive synchronised cycles an input change must persist before acceptance; legal range ≥ 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: stability counter width (derived, not overridden).
- Ports:
  - `CLOCK_50`, input, 1: sole clock, rising edge.
  - `KEY`, input, 1: reset, asynchronous, active-low.
  - `btn_n`, input, 1: raw pushbutton, active-low (0 = pressed), asynchronous to `CLOCK_50`, bouncing.
  - `btn_level`, output, 1: debounced state; 1 = pressed.
  - `press_pulse`, output, 1: one-cycle strobe on an accepted press.
  - `release_pulse`, output, 1: one-cycle strobe on an accepted release.
  - `press_count`, output, 8: number of accepted presses, modulo 256.

## Operation
- Input path: `btn_n` passes through a 2-flop synchroniser; both flops reset to 1 (released).
- FSM states and transitions:
  - `UP`: stable released. Leave for `WAIT_DN` when the synchronised input is 0; clear the stability counter.
  - `WAIT_DN`: counter increments every cycle the synchronised input is 0.
    - Synchronised input returns to 1 before the count completes: go back to `UP`, clear the counter, no strobe.
    - Count reaches `STABLE_CYCLES-1` with input still 0: go to `DN`, pulse `press_pulse`, increment `press_count`.
  - `DN`: stable pressed. Leave for `WAIT_UP` when the synchronised input is 1; clear the counter.
  - `WAIT_UP`: mirror of `WAIT_DN`.
    - Bounce (input back to 0): go back to `DN`, no strobe.
    - Completion: go to `UP`, pulse `release_pulse`.
- `btn_level` = 1 in `DN` and `WAIT_UP`, 0 in `UP` and `WAIT_DN`. It is registered and changes only on acceptance.
- `press_count` wraps 255 → 0 with no flag and no saturation.
- `press_pulse` and `release_pulse` are mutually exclusive and never asserted in consecutive cycles. A new acceptance needs at least `STABLE_CYCLES` more cycles.
- The stability counter is `CNT_W` bits and never exceeds `STABLE_CYCLES-1`. It holds at 0 in `UP` and `DN`.

## Timing
- Reset (`KEY` = 0), asynchronous:
  - FSM goes to `UP`; synchroniser flops go to 1; counter goes to 0.
  - `btn_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `press_count` = 0, all immediately.
- Reset asserted mid-`WAIT_DN` or mid-`DN` discards the pending or held press and emits no strobe.
- Reset deassertion: the first active edge is the first edge at which `KEY` is sampled high.
- Latency: let E be the first rising edge that samples `btn_n` = 0, with the input held clean afterwards.
  - `press_pulse` is high for exactly the cycle after edge E + 1 + `STABLE_CYCLES`.
  - `btn_level` rises on edge E + 1 + `STABLE_CYCLES`.
  - Release has the same latency.
- Any single-cycle glitch shorter than `STABLE_CYCLES` synchronised cycles produces no output change.
- `btn_n` held low through reset release is accepted as a press after full latency, counted from the first post-reset edge.

## Structure
- Shared header `key_defs.vh` holds:
  - the FSM state encoding as localparams `ST_UP=2'd0`, `ST_WAIT_DN=2'd1`, `ST_DN=2'd2`, `ST_WAIT_UP=2'd3`;
  - the default `STABLE_CYCLES` for board builds and a separate small simulation default.
- Sub-module `sync_2ff` (`CLOCK_50`, `KEY`, async in, sync out, reset value parameter) is reused for any other board input.
- Top `key_debouncer` contains the FSM, stability counter, strobe registers and press counter.

## Test plan
All scenarios use `STABLE_CYCLES` = 4 and a 20-unit clock period.
- Reset: `KEY` = 0 with `btn_n` toggling → all outputs 0, `press_count` = 0, throughout and asynchronously.
- Clean press: `btn_n` driven 1 → 0 before edge E and held → `press_pulse` high only in the cycle after edge E+5; `btn_level` = 1 from E+5; `press_count` = 1.
- Bounce: `btn_n` low 2 cycles, high 1 cycle, low 2 cycles, then high → no `press_pulse`, `btn_level` stays 0, `press_count` stays 0.
- Release with bounce: from `DN`, `btn_n` high 3 cycles, low 1 cycle, then high held → exactly one `release_pulse`, 5 edges after the final rising sample; `btn_level` → 0.
- Wrap: 256 clean press/release pairs → `press_count` returns to 0 after the 256th press; exactly 256 `press_pulse` strobes.
- Reset mid-operation: `KEY` pulsed low during `WAIT_DN` at count 2 → no strobe, outputs 0; with `btn_n` still held low, a press is accepted after full latency from the first post-reset edge.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding,
// stability-time defaults for board and simulation builds, counter widths.
package key_debouncer_pkg;

  // FSM encoding is fixed so other blocks and waveforms can decode it directly.
  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_WAIT_DN = 2'd1,
    ST_DN      = 2'd2,
    ST_WAIT_UP = 2'd3
  } key_state_e;

  // 20 ms at 50 MHz for the board; a tiny value keeps simulations short.
  localparam int unsigned BOARD_STABLE_CYCLES = 1_000_000;
  localparam int unsigned SIM_STABLE_CYCLES   = 4;

  localparam int unsigned PRESS_CNT_W = 8;

  // True in the states where the button is considered held down.
  function automatic logic state_is_pressed(input key_state_e st);
    return (st == ST_DN) || (st == ST_WAIT_UP);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input; the reset
// value is chosen per input so the idle level is seen during and after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLOCK_50,
  input  logic KEY,
  input  logic async_in,
  output logic sync_out
);

  logic stage1_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs before either updates, forming a true shift chain.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      stage1_q <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      stage1_q <= async_in;
      sync_out <= stage1_q;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Debounces one active-low pushbutton into a clean level, one-cycle
// press/release strobes and a wrapping 8-bit count of accepted presses.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = BOARD_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                   CLOCK_50,
  input  logic                   KEY,
  input  logic                   btn_n,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // The cycle that enters a WAIT state already counts as the first stable
  // cycle, so acceptance happens when the counter shows STABLE_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic btn_sync_n;
  logic pressed;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, release_d, level_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_btn_sync (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .async_in (btn_n),
    .sync_out (btn_sync_n)
  );

  assign pressed = ~btn_sync_n;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch; the counter defaults to cleared.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      ST_UP: begin
        if (pressed) state_d = ST_WAIT_DN;
      end

      ST_WAIT_DN: begin
        if (!pressed) begin
          state_d = ST_UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DN: begin
        if (!pressed) state_d = ST_WAIT_UP;
      end

      ST_WAIT_UP: begin
        if (pressed) begin
          state_d = ST_DN;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_UP;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_UP;
    endcase

    level_d = state_is_pressed(state_d);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q <= ST_UP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered so downstream logic never sees decode glitches.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      if (press_d) press_count <= press_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: run-length reference model checked every cycle,
// plus directed timing, bounce, wrap and reset scenarios with STABLE_CYCLES=4.
module tb_key_debouncer;
  import key_debouncer_pkg::*;

  localparam int S = SIM_STABLE_CYCLES;

  logic       CLOCK_50 = 1'b0;
  logic       KEY      = 1'b0;
  logic       btn_n    = 1'b1;
  logic       btn_level, press_pulse, release_pulse;
  logic [7:0] press_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int press_seen   = 0;
  int release_seen = 0;
  int base;

  key_debouncer #(
    .STABLE_CYCLES (S)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .KEY           (KEY),
    .btn_n         (btn_n),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #5;
  endtask

  // Reference model: the FSM sees btn_n two edges late; the level flips once
  // S consecutive seen samples disagree with it.
  bit         m_hist[$] = {1'b1, 1'b1};
  bit         m_level   = 1'b0;
  bit         m_press   = 1'b0;
  bit         m_release = 1'b0;
  int         m_run     = 0;
  logic [7:0] m_count   = 8'd0;

  always @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      m_hist    = {1'b1, 1'b1};
      m_level   = 1'b0;
      m_press   = 1'b0;
      m_release = 1'b0;
      m_run     = 0;
      m_count   = 8'd0;
    end else begin
      bit seen_pressed;
      m_hist.push_back(btn_n);
      seen_pressed = !m_hist.pop_front();
      m_press   = 1'b0;
      m_release = 1'b0;
      if (seen_pressed != m_level) m_run++;
      else m_run = 0;
      if (m_run == S) begin
        m_level = !m_level;
        m_run   = 0;
        if (m_level) begin
          m_press = 1'b1;
          m_count = m_count + 8'd1;
        end else begin
          m_release = 1'b1;
        end
      end
    end
  end

  bit prev_strobe = 1'b0;

  always @(negedge CLOCK_50) begin
    check("level", btn_level, m_level);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_release);
    check("press_count", press_count, m_count);
    check("strobe_excl", press_pulse & release_pulse, 0);
    check("strobe_consec", (press_pulse | release_pulse) & prev_strobe, 0);
    prev_strobe = press_pulse | release_pulse;
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) release_seen++;
  end

  initial begin
    // Reset held with a toggling button: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      btn_n = ~btn_n;
      check("rst_level", btn_level, 0);
      check("rst_press", press_pulse, 0);
      check("rst_count", press_count, 0);
    end
    btn_n = 1'b1;
    cycles(1);
    KEY = 1'b1;
    cycles(3);

    // Clean press: strobe in the cycle after E+5, level from E+5.
    btn_n = 1'b0;
    @(posedge CLOCK_50);
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLOCK_50);
      #1;
      check("press_timing", press_pulse, (k == 5));
      check("press_level", btn_level, (k >= 5));
    end
    check("press_count_1", press_count, 1);
    check("model_count_1", m_count, 1);
    #4;

    // Clean release with the same latency.
    btn_n = 1'b1;
    @(posedge CLOCK_50);
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLOCK_50);
      #1;
      check("release_timing", release_pulse, (k == 5));
      check("release_level", btn_level, (k < 5));
    end
    #4;

    // Bounce: low 2, high 1, low 2, then high -- never accepted.
    base = press_seen;
    btn_n = 1'b0; cycles(2);
    btn_n = 1'b1; cycles(1);
    btn_n = 1'b0; cycles(2);
    btn_n = 1'b1; cycles(10);
    check("bounce_no_press", press_seen - base, 0);
    check("bounce_level", btn_level, 0);
    check("bounce_count", press_count, 1);

    // Release with bounce from DN: high 3, low 1, then high held.
    btn_n = 1'b0; cycles(8);
    check("held_level", btn_level, 1);
    base = release_seen;
    btn_n = 1'b1; cycles(3);
    btn_n = 1'b0; cycles(1);
    btn_n = 1'b1;
    @(posedge CLOCK_50);
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLOCK_50);
      #1;
      check("bounce_rel_timing", release_pulse, (k == 5));
      check("bounce_rel_level", btn_level, (k < 5));
    end
    #4;
    check("bounce_rel_once", release_seen - base, 1);
    check("press_count_2", press_count, 2);

    // Random hold lengths straddling the stability window.
    for (int i = 0; i < 300; i++) begin
      btn_n = 1'($urandom_range(0, 1));
      cycles(int'($urandom_range(1, 9)));
    end
    btn_n = 1'b1;
    cycles(10);

    // Asynchronous reset while held: outputs clear before any clock edge.
    btn_n = 1'b0; cycles(8);
    check("pre_rst_level", btn_level, 1);
    KEY = 1'b0;
    #1;
    check("async_level", btn_level, 0);
    check("async_count", press_count, 0);
    btn_n = 1'b1;
    cycles(2);
    KEY = 1'b1;
    cycles(3);

    // Wrap: 256 clean presses bring the count back to zero.
    base = press_seen;
    for (int i = 0; i < 256; i++) begin
      btn_n = 1'b0; cycles(7);
      if (i == 127) check("wrap_mid", press_count, 128);
      btn_n = 1'b1; cycles(7);
    end
    check("wrap_count", press_count, 0);
    check("wrap_strobes", press_seen - base, 256);

    // Reset during WAIT_DN at count 2, button still held through release.
    btn_n = 1'b0;
    @(posedge CLOCK_50);
    repeat (4) @(posedge CLOCK_50);
    #5;
    base = press_seen;
    KEY = 1'b0;
    #1;
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_press", press_pulse, 0);
    #4;
    cycles(3);
    KEY = 1'b1;
    @(posedge CLOCK_50);
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLOCK_50);
      #1;
      check("post_rst_timing", press_pulse, (k == 5));
      check("post_rst_level", btn_level, (k >= 5));
    end
    #4;
    check("post_rst_count", press_count, 1);
    check("post_rst_strobes", press_seen - base, 1);

    btn_n = 1'b1;
    cycles(10);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
